// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch unit: FSM encodings and default widths.
package fetch_pkg;

    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 16;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t IDLE = 2'd0;
    localparam fetch_state_t WAIT = 2'd1;
    localparam fetch_state_t HOLD = 2'd2;

endpackage

// File: rtl/fetch_watchdog.sv
// Counts WAIT cycles and flags expiry on the TIMEOUT-th cycle without a response.
module fetch_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (clr || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_expire) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expire = i_enable && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetches one word at pc_in, holds it for the decoder and pulses incPC once per fetch.
// Optional WAIT timeout with sticky fetch_err is enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_load,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] ir_out,
    output logic              ir_valid,
    input  logic              ir_ack,
    output logic              incPC,
    output logic              fetch_err
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd;
    logic [DATA_W-1:0] r_ir_out;
    logic              r_ir_valid;
    logic              r_incPC;
    logic              w_expire;
    logic              w_err_block;

`ifdef FETCH_TIMEOUT_EN
    logic r_fetch_err;

    fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .clr      (clr),
        .i_clear  (pc_load || (r_state != WAIT)),
        .i_enable (r_state == WAIT),
        .o_expire (w_expire)
    );

    // A redirect gives software a way out of a hung fetch without a full reset.
    always_ff @(posedge clk) begin
        if (clr || pc_load) begin
            r_fetch_err <= 1'b0;
        end else if ((r_state == WAIT) && !mem_ready && w_expire) begin
            r_fetch_err <= 1'b1;
        end
    end

    assign w_err_block = r_fetch_err;
    assign fetch_err   = r_fetch_err;
`else
    assign w_expire    = 1'b0;
    assign w_err_block = 1'b0;
    assign fetch_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= IDLE;
            r_mem_addr <= '0;
            r_mem_rd   <= 1'b0;
            r_ir_out   <= '0;
            r_ir_valid <= 1'b0;
            r_incPC    <= 1'b0;
        end else begin
            r_incPC <= 1'b0;
            if (pc_load) begin
                r_mem_rd   <= 1'b0;
                r_ir_valid <= 1'b0;
                r_state    <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (fetch_en && !w_err_block) begin
                            r_mem_addr <= pc_in;
                            r_mem_rd   <= 1'b1;
                            r_state    <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (mem_ready) begin
                            r_ir_out   <= mem_data;
                            r_ir_valid <= 1'b1;
                            r_mem_rd   <= 1'b0;
                            r_incPC    <= 1'b1;
                            r_state    <= HOLD;
                        end else if (w_expire) begin
                            r_mem_rd <= 1'b0;
                            r_state  <= IDLE;
                        end
                    end
                    // Always exit via IDLE so the PC has absorbed incPC before the next sample.
                    HOLD: begin
                        if (ir_ack) begin
                            r_ir_valid <= 1'b0;
                            r_state    <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign mem_addr = r_mem_addr;
    assign mem_rd   = r_mem_rd;
    assign ir_out   = r_ir_out;
    assign ir_valid = r_ir_valid;
    assign incPC    = r_incPC;

endmodule
